// File: rtl/pp_accumulator.sv
// -----------------------------------------------------------------------------
// pp_accumulator
//
// Sums the shifted partial products of one multiplication, which arrive as
// 4x4 tile products from a pipelined tile multiplier, and holds the 32-bit
// result until the consumer takes it.
//
// Each accepted word contributes term = pp_data << (4 * pp_shift). The first
// word of an operation replaces the accumulator. Later words add to it,
// modulo 2^32. The word flagged pp_last completes the operation, and the
// block then holds the result until it is delivered.
//
// Handshakes (both sides):
//   A transfer happens on a rising clk edge where valid & ready are both high
//   and ena is high. The producer keeps its data stable while valid is high
//   and no transfer has happened. The ready outputs do not depend on the
//   valid inputs.
//   pp side : accept  = pp_valid & pp_ready, where pp_ready = ena & !HOLD.
//   res side: deliver = res_valid & res_ready & ena, where res_valid = HOLD.
//
// Optional feature:
//   PP_ACC_OVF_EN  When this macro is defined, res_ovf is a sticky flag. It is
//                  set when any accepted term, or any carry, reaches sum bits
//                  [35:32]. It is cleared on the first word of each operation.
//                  When the macro is undefined, res_ovf is tied low and
//                  wrap-around is silent.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   ena          in   stage enable; low freezes all state
//   pp_valid     in   partial-product word present
//   pp_ready     out  partial product accepted this cycle if pp_valid
//   pp_data[7:0] in   unsigned 4x4 tile product
//   pp_shift[2:0]in   tile weight in nibbles
//   pp_last      in   final partial product of the operation
//   res_valid    out  result available
//   res_ready    in   consumer accepts the result
//   res_data[31:0] out accumulator (registered); meaningful while res_valid
//   res_ovf      out  sticky overflow for the current result
//   dbg_state_o[1:0] out current FSM state (0 IDLE, 1 ACCUM, 2 HOLD)
// -----------------------------------------------------------------------------
module pp_accumulator (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        pp_valid,
    output logic        pp_ready,
    input  logic [7:0]  pp_data,
    input  logic [2:0]  pp_shift,
    input  logic        pp_last,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_ovf,
    output logic [1:0]  dbg_state_o
);

`ifdef PP_ACC_OVF_EN
    // Four guard bits above the 32-bit accumulator catch both oversized
    // terms (shift 7) and carries out of bit 31.
    localparam int SW = 36;
`else
    localparam int SW = 32;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [31:0]    acc_q, acc_d;
    logic           accept;
    logic           deliver;
    logic [5:0]     shamt;
    logic [SW-1:0]  term;
    logic [SW-1:0]  sum;

    assign pp_ready    = ena & (state_q != S_HOLD);
    assign res_valid   = (state_q == S_HOLD);
    assign accept      = pp_valid & pp_ready;
    assign deliver     = res_valid & res_ready & ena;
    assign res_data    = acc_q;
    assign dbg_state_o = state_q;

    // The shift amount is 4 * pp_shift, so its maximum is 28. With a shift
    // of 7, the top nibble of pp_data lands in the guard bits, or is dropped
    // when there are no guard bits.
    assign shamt = {1'b0, pp_shift, 2'b00};
    assign term  = SW'(pp_data) << shamt;

    // In IDLE the old accumulator is discarded, so the base is zero.
    assign sum = ((state_q == S_IDLE) ? '0 : SW'(acc_q)) + term;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        case (state_q)
            S_IDLE, S_ACCUM: begin
                if (accept) begin
                    acc_d   = sum[31:0];
                    state_d = pp_last ? S_HOLD : S_ACCUM;
                end
            end
            S_HOLD: begin
                if (deliver) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
        end
    end

`ifdef PP_ACC_OVF_EN
    logic ovf_q, ovf_d;

    // The flag is sticky within an operation. The first word of a new
    // operation drops the old flag and then applies its own term.
    always_comb begin
        ovf_d = ovf_q;
        if (accept) begin
            ovf_d = ((state_q == S_IDLE) ? 1'b0 : ovf_q) | (|sum[35:32]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign res_ovf = ovf_q;
`else
    assign res_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pp_accumulator.sv
module tb_pp_accumulator;

  logic        clk;
  logic        rst;
  logic        ena;
  logic        pp_valid;
  logic        pp_ready;
  logic [7:0]  pp_data;
  logic [2:0]  pp_shift;
  logic        pp_last;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_ovf;
  logic [1:0]  dbg_state;

`ifdef PP_ACC_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  // Scoreboard entries are {res_ovf, res_data}.
  logic [32:0] exp_q[$];

  pp_accumulator dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .pp_valid   (pp_valid),
    .pp_ready   (pp_ready),
    .pp_data    (pp_data),
    .pp_shift   (pp_shift),
    .pp_last    (pp_last),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_ovf    (res_ovf),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1;
    ena = 1'b1;
    pp_valid = 1'b0;
    pp_data = 8'h00;
    pp_shift = 3'd0;
    pp_last = 1'b0;
    res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  // Every task starts and ends #1 after a rising edge.
  task automatic send_pp(input logic [7:0] d, input logic [2:0] s, input logic l);
    int n;
    n = 0;
    pp_valid = 1'b1;
    pp_data = d;
    pp_shift = s;
    pp_last = l;
    while (!pp_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!pp_ready) begin
      tests_run++;
      tests_failed++;
      $display("FAIL send_pp_timeout: pp_ready=%0b after %0d cycles, required 1", pp_ready, n);
    end
    @(posedge clk);
    #1;
    pp_valid = 1'b0;
    pp_last = 1'b0;
  endtask

  // Waits for a delivery, then checks it against the head of the scoreboard.
  task automatic wait_result(input string name);
    int n;
    logic [32:0] exp;
    n = 0;
    while (!(res_valid && res_ready && ena) && n < 100) begin
      @(negedge clk);
      n++;
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h0;
    tests_run++;
    if (!(res_valid && res_ready && ena)) begin
      tests_failed++;
      $display("FAIL %s_timeout: res_valid=%0b, required a delivery within 100 cycles", name, res_valid);
    end else begin
      if (res_data !== exp[31:0]) begin
        tests_failed++;
        $display("FAIL %s_data: got %h, expected %h", name, res_data, exp[31:0]);
      end
      tests_run++;
      if (res_ovf !== exp[32]) begin
        tests_failed++;
        $display("FAIL %s_ovf: got %0b, expected %0b", name, res_ovf, exp[32]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0b, expected %0b", name, got, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    check1("reset_res_valid", res_valid, 1'b0);
    check1("reset_pp_ready", pp_ready, 1'b1);
    check32("reset_res_data", res_data, 32'h0);
    check1("reset_res_ovf", res_ovf, 1'b0);
  endtask

  task automatic test_8x8();
    exp_q.push_back({1'b0, 32'h000088EF});
    send_pp(8'h8F, 3'd0, 1'b0);
    send_pp(8'h82, 3'd1, 1'b0);
    send_pp(8'h84, 3'd1, 1'b0);
    send_pp(8'h78, 3'd2, 1'b1);
    // The last word was accepted at the previous edge.
    check1("8x8_res_valid_latency", res_valid, 1'b1);
    check1("8x8_pp_ready_in_hold", pp_ready, 1'b0);
    wait_result("8x8");
    // The delivery was at the previous edge.
    check1("8x8_pp_ready_after_deliver", pp_ready, 1'b1);
  endtask

  task automatic test_16x16();
    exp_q.push_back({1'b0, 32'hFFFE0001});
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        send_pp(8'hE1, 3'(i + j), (i == 3 && j == 3));
      end
    end
    wait_result("16x16");
  endtask

  task automatic test_backpressure();
    res_ready = 1'b0;
    exp_q.push_back({1'b0, 32'h00000012});
    send_pp(8'h12, 3'd0, 1'b1);
    // This word must be ignored while the result is held.
    pp_valid = 1'b1;
    pp_data = 8'h77;
    pp_shift = 3'd3;
    pp_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check1("bp_pp_ready", pp_ready, 1'b0);
      check1("bp_res_valid", res_valid, 1'b1);
      check32("bp_res_data", res_data, 32'h00000012);
    end
    @(posedge clk);
    #1;
    pp_valid = 1'b0;
    pp_last = 1'b0;
    res_ready = 1'b1;
    wait_result("bp_held");
    exp_q.push_back({1'b0, 32'h00000050});
    send_pp(8'h05, 3'd1, 1'b1);
    wait_result("bp_fresh");
  endtask

  task automatic test_overflow();
    exp_q.push_back({OVF_EN, 32'hF0000000});
    send_pp(8'hFF, 3'd7, 1'b1);
    wait_result("ovf_shift7");
    // The flag must clear on the next operation.
    exp_q.push_back({1'b0, 32'h00000001});
    send_pp(8'h01, 3'd0, 1'b1);
    wait_result("ovf_cleared");
    // A carry out of bit 31: 0xFF000000 + 0xFF000000.
    exp_q.push_back({OVF_EN, 32'hFE000000});
    send_pp(8'hFF, 3'd6, 1'b0);
    send_pp(8'hFF, 3'd6, 1'b1);
    wait_result("ovf_carry");
  endtask

  task automatic test_stall();
    exp_q.push_back({1'b0, 32'h00000310});
    send_pp(8'h10, 3'd0, 1'b0);
    ena = 1'b0;
    pp_valid = 1'b1;
    pp_data = 8'h20;
    pp_shift = 3'd1;
    pp_last = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check1("stall_pp_ready", pp_ready, 1'b0);
      check1("stall_res_valid", res_valid, 1'b0);
      check32("stall_acc_frozen", res_data, 32'h00000010);
    end
    @(posedge clk);
    #1;
    ena = 1'b1;
    pp_valid = 1'b0;
    pp_last = 1'b0;
    send_pp(8'h03, 3'd2, 1'b1);
    wait_result("stall_resume");
  endtask

  task automatic test_reset_mid();
    send_pp(8'h33, 3'd0, 1'b0);
    // A handshake in the same cycle as the reset must lose.
    rst = 1'b1;
    pp_valid = 1'b1;
    pp_data = 8'h44;
    pp_last = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    pp_valid = 1'b0;
    pp_last = 1'b0;
    check32("rstmid_acc", res_data, 32'h0);
    check1("rstmid_res_valid", res_valid, 1'b0);
    check1("rstmid_pp_ready", pp_ready, 1'b1);
    exp_q.push_back({1'b0, 32'h0000002A});
    send_pp(8'h2A, 3'd0, 1'b1);
    wait_result("rstmid_next");
  endtask

  task automatic test_random();
    logic [31:0] m_acc;
    logic        m_ovf;
    logic [63:0] s;
    logic [7:0]  d;
    logic [2:0]  sh;
    int          beats;
    for (int op = 0; op < 8; op++) begin
      beats = $urandom_range(1, 6);
      m_acc = 32'h0;
      m_ovf = 1'b0;
      for (int b = 0; b < beats; b++) begin
        d = 8'($urandom_range(0, 255));
        sh = 3'($urandom_range(0, 7));
        s = 64'(m_acc) + (64'(d) << (4 * sh));
        if (s >= 64'h1_0000_0000) m_ovf = 1'b1;
        m_acc = s[31:0];
        if (b == beats - 1) exp_q.push_back({OVF_EN & m_ovf, m_acc});
        send_pp(d, sh, (b == beats - 1));
      end
      wait_result("random");
    end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    do_reset();
    test_reset();
    test_8x8();
    test_16x16();
    test_backpressure();
    test_overflow();
    test_stall();
    test_reset_mid();
    test_random();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pp_accumulator.md
PP_ACCUMULATOR -- requirements
Module: pp_accumulator

Interface
REQ-001 Clock and reset: one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 ena  input  1  stage enable; low = stall, all state frozen.
REQ-005 pp_valid  input  1  partial-product word present.
REQ-006 pp_ready  output  1  block accepts a partial product this cycle.
REQ-007 pp_data  input  8  unsigned 4x4 tile product from the pipelined tile multiplier.
REQ-008 pp_shift  input  3  tile weight in nibbles (term = pp_data << 4*pp_shift).
REQ-009 pp_last  input  1  marks the final partial product of one operation.
REQ-010 res_valid  output  1  accumulated result available.
REQ-011 res_ready  input  1  consumer accepts the result.
REQ-012 res_data  output  32  accumulated result, registered.
REQ-013 res_ovf  output  1  sticky overflow for the current result (see Configuration).

Function
REQ-014 FSM states: IDLE, ACCUM, HOLD; accept = pp_valid & pp_ready; deliver = res_valid & res_ready & ena.
REQ-015 pp_ready = ena & (state != HOLD); res_valid = (state == HOLD).
REQ-016 IDLE, on accept: acc <= term (previous value discarded); next = HOLD if pp_last, else ACCUM.
REQ-017 ACCUM, on accept: acc <= acc + term, modulo 2^32; next = HOLD if pp_last, else ACCUM.
REQ-018 ACCUM with no accept: acc and state unchanged; there is no timeout.
REQ-019 HOLD: res_data = acc and stays stable; on deliver, next = IDLE; pp_valid is ignored.
REQ-020 Latency: last accepted at edge N gives res_valid high from N+1; deliver at edge M gives pp_ready high from M+1.
REQ-021 Term width: internal sum is 36 bits; result bits [31:0] go to acc; bits [35:32] feed overflow detection only.
REQ-022 pp_shift 0..6 are legal for 16x16 operations; 7 is accepted, and only its bits below 32 reach acc.
REQ-023 Any number of partial products is accepted per operation, in any shift order; a single pp_last word is a complete operation.
REQ-024 ena low: no accept, no deliver, no state, acc or res_ovf change; res_valid and res_data hold their values.
REQ-025 res_data always drives acc; consumers shall sample it only while res_valid is high.

Reset
REQ-026 On rst at a clock edge: state = IDLE, acc = 0, res_ovf = 0, res_valid = 0; pp_ready = ena from the next cycle.
REQ-027 rst overrides ena and any handshake in the same cycle; an operation in progress is discarded with no result.

Configuration
REQ-028 Macro PP_ACC_OVF_EN compiled in: res_ovf is set when any accepted term or carry has nonzero sum bits [35:32].
REQ-029 With PP_ACC_OVF_EN: res_ovf is cleared on the first accept in IDLE, then re-evaluated with that term.
REQ-030 With PP_ACC_OVF_EN: res_ovf is valid alongside res_valid.
REQ-031 Without PP_ACC_OVF_EN: res_ovf is tied to 0, no overflow logic is built, and wrap-around is silent.

Verification
REQ-032 8x8 0xAB*0xCD: pp (0x8F,s0) (0x82,s1) (0x84,s1) (0x78,s2,last) -> res_data 0x000088EF, res_ovf 0, res_valid one cycle after last.
REQ-033 16x16 0xFFFF*0xFFFF: 16 tiles of 0xE1 at shifts i+j, last on the 16th -> res_data 0xFFFE0001, res_ovf 0.
REQ-034 Backpressure: hold res_ready low 5 cycles after a result while pp_valid is high -> pp_ready 0 and res_data stable; res_ready high -> IDLE, next operation starts fresh.
REQ-035 Overflow: (0xFF,s7,last) -> res_data 0xF0000000; res_ovf 1 with PP_ACC_OVF_EN, 0 without.
REQ-036 Stall/reset: ena low for 3 cycles mid-ACCUM -> acc frozen and result correct after resuming; rst mid-ACCUM -> IDLE, acc 0, and the next (0x2A,s0,last) gives 0x0000002A.
